// File: rtl/score_bcd_keeper_pkg.sv
// score_bcd_keeper_pkg: shared game-state codes, score sizing and converter states.
package score_bcd_keeper_pkg;
  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_FLY = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;
  localparam int SCORE_W = 11;
  localparam int DIGITS = 3;
  localparam int MAX_SCORE = 999;
  localparam int BCD_W = 4 * DIGITS;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} conv_state_t;
endpackage

// File: rtl/score_bcd_keeper_seq_bin2bcd.sv
// seq_bin2bcd: serial shift-add-3 binary to BCD engine, one bit per step.
module seq_bin2bcd #(
  parameter int W = 11,
  parameter int D = 3
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic step,
  input logic [W-1:0] bin,
  output logic [4*D-1:0] bcd,
  output logic done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] sh;
  logic [4*D-1:0] adj;
  logic [CW-1:0] cnt;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
  always_comb begin
    adj = '0;
    for (int i = 0; i < D; i++) adj[4*i +: 4] = add3(bcd[4*i +: 4]);
  end
  // done flags the step that consumes the final binary bit
  assign done = cnt == CW'(W - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd <= '0;
      sh <= '0;
      cnt <= '0;
    end else if (start) begin
      bcd <= '0;
      sh <= bin;
      cnt <= '0;
    end else if (step) begin
      {bcd, sh} <= {adj[4*D-2:0], sh, 1'b0};
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/score_bcd_keeper.sv
// score_bcd_keeper: saturating pipe score with serial BCD conversion for the display.
// Optional best-score tracking is built when SCORE_HISCORE_EN is defined.
module score_bcd_keeper
  import score_bcd_keeper_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic [1:0] game_state,
  input logic pass_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [BCD_W-1:0] score_bcd,
  output logic bcd_valid,
  output logic busy,
  output logic [BCD_W-1:0] hiscore_bcd,
  output logic new_best
);
  conv_state_t state, nstate;
  logic clr, dirty, start, step, done;
  logic [SCORE_W-1:0] last_conv;
  logic [BCD_W-1:0] conv_bcd;
  assign clr = game_state != ST_FLY && game_state != ST_DEAD;
  assign dirty = score != last_conv;
  always_ff @(posedge clk) begin
    if (rst || clr) score <= '0;
    else if (game_state == ST_FLY && pass_pulse && score != SCORE_W'(MAX_SCORE)) score <= score + 1'b1;
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : nstate;
  always_comb begin
    nstate = (state == S_IDLE) ? (dirty ? S_SHIFT : S_IDLE) :
             (state == S_SHIFT) ? (done ? S_DONE : S_SHIFT) : S_IDLE;
  end
  always_comb begin
    start = state == S_IDLE && dirty;
    step = state == S_SHIFT;
    busy = state != S_IDLE;
  end
  // last_conv doubles as the snapshot: it only moves when a conversion starts
  always_ff @(posedge clk) begin
    if (rst) begin
      last_conv <= '0;
      score_bcd <= '0;
      bcd_valid <= 1'b0;
    end else begin
      if (start) last_conv <= score;
      if (state == S_DONE) score_bcd <= conv_bcd;
      bcd_valid <= state == S_DONE;
    end
  end
  seq_bin2bcd #(.W(SCORE_W), .D(DIGITS)) u_conv (
    .clk(clk),
    .rst(rst),
    .start(start),
    .step(step),
    .bin(score),
    .bcd(conv_bcd),
    .done(done)
  );
`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] best_bin;
  logic better;
  assign better = state == S_DONE && last_conv > best_bin;
  always_ff @(posedge clk) begin
    if (rst) begin
      best_bin <= '0;
      hiscore_bcd <= '0;
      new_best <= 1'b0;
    end else begin
      if (better) begin
        best_bin <= last_conv;
        hiscore_bcd <= conv_bcd;
      end
      new_best <= clr ? 1'b0 : better ? 1'b1 : new_best;
    end
  end
`else
  assign hiscore_bcd = '0;
  assign new_best = 1'b0;
`endif
endmodule

// File: tb/tb_score_bcd_keeper.sv
// tb_score_bcd_keeper: directed checks of counting, saturation, coalesced conversion and reset abort.
module tb_score_bcd_keeper;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] game_state;
  logic pass_pulse;
  logic [10:0] score;
  logic [11:0] score_bcd, hiscore_bcd;
  logic bcd_valid, busy, new_best;
  int n_tests = 0;
  int n_fail = 0;
  int first, cnt;
  logic [11:0] last;
  score_bcd_keeper dut (
    .clk(clk),
    .rst(rst),
    .game_state(game_state),
    .pass_pulse(pass_pulse),
    .score(score),
    .score_bcd(score_bcd),
    .bcd_valid(bcd_valid),
    .busy(busy),
    .hiscore_bcd(hiscore_bcd),
    .new_best(new_best)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulses(input int n);
    repeat (n) begin
      pass_pulse = 1'b1;
      @(negedge clk);
    end
    pass_pulse = 1'b0;
  endtask
  task automatic settle();
    repeat (40) @(negedge clk);
  endtask
  task automatic watch(input int n, output int f, output int c, output logic [11:0] l);
    f = -1;
    c = 0;
    l = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (bcd_valid) begin
        if (f < 0) f = k;
        c++;
        l = score_bcd;
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    game_state = 2'd0;
    pass_pulse = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_score", score, 0);
    chk("rst_bcd", score_bcd, 12'h000);
    chk("rst_valid", bcd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hiscore", hiscore_bcd, 12'h000);
    chk("rst_new_best", new_best, 0);
    game_state = 2'd1;
    pass_pulse = 1'b1;
    @(negedge clk);
    pass_pulse = 1'b0;
    chk("one_score", score, 1);
    @(negedge clk);
    chk("one_busy", busy, 1);
    watch(30, first, cnt, last);
    chk("one_latency", first + 1, 13);
    chk("one_valid_count", cnt, 1);
    chk("one_bcd", last, 12'h001);
    chk("one_idle", busy, 0);
    pulses(1010);
    chk("sat_score", score, 999);
    settle();
    chk("sat_bcd", score_bcd, 12'h999);
    chk("sat_hold", score, 999);
`ifndef SCORE_HISCORE_EN
    chk("off_hiscore", hiscore_bcd, 12'h000);
    chk("off_new_best", new_best, 0);
`endif
    game_state = 2'd0;
    @(negedge clk);
    chk("clr_score", score, 0);
    watch(40, first, cnt, last);
    chk("clr_valid_count", cnt, 1);
    chk("clr_bcd", score_bcd, 12'h000);
    game_state = 2'd1;
    pulses(3);
    game_state = 2'd2;
    pulses(4);
    chk("dead_ignore", score, 3);
    game_state = 2'd3;
    @(negedge clk);
    chk("gs3_clear", score, 0);
    game_state = 2'd1;
    pulses(47);
    settle();
    chk("pre47_bcd", score_bcd, 12'h047);
    pulses(3);
    chk("burst_score", score, 50);
    watch(40, first, cnt, last);
    chk("burst_conv_count", cnt, 2);
    chk("burst_last_bcd", last, 12'h050);
    chk("burst_final_bcd", score_bcd, 12'h050);
    game_state = 2'd0;
    @(negedge clk);
    game_state = 2'd1;
    pulses(127);
    settle();
    chk("pre128_bcd", score_bcd, 12'h127);
    pulses(1);
    repeat (6) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", score_bcd, 12'h000);
    chk("abort_score", score, 0);
    chk("abort_valid", bcd_valid, 0);
    watch(30, first, cnt, last);
    chk("abort_no_valid", cnt, 0);
`ifdef SCORE_HISCORE_EN
    pulses(12);
    settle();
    chk("g1_hiscore", hiscore_bcd, 12'h012);
    chk("g1_new_best", new_best, 1);
    game_state = 2'd0;
    @(negedge clk);
    game_state = 2'd1;
    chk("g2_new_best_clr", new_best, 0);
    pulses(8);
    settle();
    chk("g2_hiscore_keep", hiscore_bcd, 12'h012);
    chk("g2_new_best_low", new_best, 0);
    pulses(5);
    settle();
    chk("g2_hiscore_13", hiscore_bcd, 12'h013);
    chk("g2_new_best_13", new_best, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
